// File: rtl/viterbi_pkg.sv
// Shared constants for the K=3, rate-1/2 Viterbi decoder.
// Trellis tables and FSM encodings used by the ACS/path-metric stage.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int BM_W       = 2;
    localparam int NUM_BR     = 2 * NUM_STATES;

    // Predecessors of each new state: pred0 is the lower-index one.
    localparam int PRED0 [NUM_STATES] = '{0, 2, 0, 2};
    localparam int PRED1 [NUM_STATES] = '{1, 3, 1, 3};

    // Branch-metric index (0-based hamd_n - 1) for each (state, pred).
    localparam int BR0 [NUM_STATES] = '{0, 2, 4, 6};
    localparam int BR1 [NUM_STATES] = '{1, 3, 5, 7};

    typedef logic [1:0] fsm_t;

    localparam fsm_t IDLE = 2'd0;
    localparam fsm_t RUN  = 2'd1;
    localparam fsm_t DONE = 2'd2;

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select butterfly half.
// Sums are formed one bit wider than the metric so they never wrap.
module acs_cell
    import viterbi_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [BM_W-1:0] bm0,
    input  logic [BM_W-1:0] bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    logic [PM_W:0] cand0;
    logic [PM_W:0] cand1;

    assign cand0 = {1'b0, pm0} + (PM_W+1)'(bm0);
    assign cand1 = {1'b0, pm1} + (PM_W+1)'(bm1);

    // Ties keep pred0.
    assign dec    = (cand1 < cand0);
    assign pm_new = dec ? cand1[PM_W-1:0] : cand0[PM_W-1:0];

endmodule

// File: rtl/acs_pm.sv
// ACS and path-metric stage: four path metrics, survivor decisions,
// and end-of-frame best state / metric report.
module acs_pm
    import viterbi_pkg::*;
#(
    parameter int PM_W    = 8,
    parameter int INIT_PM = 16,
    parameter int N_SYM   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            bm_valid,
    input  logic [1:0]      hamd_1,
    input  logic [1:0]      hamd_2,
    input  logic [1:0]      hamd_3,
    input  logic [1:0]      hamd_4,
    input  logic [1:0]      hamd_5,
    input  logic [1:0]      hamd_6,
    input  logic [1:0]      hamd_7,
    input  logic [1:0]      hamd_8,
    output logic [3:0]      dec_bits,
    output logic            dec_valid,
    output logic [1:0]      best_state,
    output logic [PM_W-1:0] best_pm,
    output logic            frame_done,
    output logic            busy
);

    localparam int CNT_W = $clog2(N_SYM + 1);
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(INIT_PM);

    fsm_t             state;
    logic [CNT_W-1:0] cnt;
    logic [PM_W-1:0]  pm   [NUM_STATES];
    logic [PM_W-1:0]  sel  [NUM_STATES];
    logic [PM_W-1:0]  nxt  [NUM_STATES];
    logic [BM_W-1:0]  bm   [NUM_BR];
    logic [3:0]       dec;
    logic             all_msb;
    logic [1:0]       arg;
    logic [PM_W-1:0]  amin;

    assign bm[0] = hamd_1;
    assign bm[1] = hamd_2;
    assign bm[2] = hamd_3;
    assign bm[3] = hamd_4;
    assign bm[4] = hamd_5;
    assign bm[5] = hamd_6;
    assign bm[6] = hamd_7;
    assign bm[7] = hamd_8;

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        acs_cell #(
            .PM_W (PM_W)
        ) u_acs (
            .pm0    (pm[PRED0[s]]),
            .pm1    (pm[PRED1[s]]),
            .bm0    (bm[BR0[s]]),
            .bm1    (bm[BR1[s]]),
            .pm_new (sel[s]),
            .dec    (dec[s])
        );
    end

    // Pull all metrics down together once every one has its MSB set.
    always_comb begin
        all_msb = 1'b1;
        for (int s = 0; s < NUM_STATES; s++) begin
            all_msb = all_msb & sel[s][PM_W-1];
        end
        for (int s = 0; s < NUM_STATES; s++) begin
            nxt[s] = sel[s];
            if (all_msb) begin
                nxt[s][PM_W-1] = 1'b0;
            end
        end
    end

    // Argmin over the registered metrics; lowest index wins ties.
    always_comb begin
        arg  = 2'd0;
        amin = pm[0];
        for (int s = 1; s < NUM_STATES; s++) begin
            if (pm[s] < amin) begin
                amin = pm[s];
                arg  = 2'(s);
            end
        end
    end

    assign busy = (state == RUN) || (state == DONE);

    // Frame FSM, step counter, metric registers and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pm[0]      <= '0;
            for (int s = 1; s < NUM_STATES; s++) begin
                pm[s] <= PM_INIT;
            end
            dec_bits   <= '0;
            dec_valid  <= 1'b0;
            best_state <= '0;
            best_pm    <= '0;
            frame_done <= 1'b0;
        end else begin
            dec_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (start) begin
                state <= RUN;
                cnt   <= '0;
                pm[0] <= '0;
                for (int s = 1; s < NUM_STATES; s++) begin
                    pm[s] <= PM_INIT;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        if (bm_valid) begin
                            for (int s = 0; s < NUM_STATES; s++) begin
                                pm[s] <= nxt[s];
                            end
                            dec_bits  <= dec;
                            dec_valid <= 1'b1;
                            cnt       <= cnt + CNT_W'(1);
                            if (cnt == CNT_W'(N_SYM - 1)) begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        best_state <= arg;
                        best_pm    <= amin;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acs_pm.sv
// Randomised and directed bench for acs_pm.
// Expected values come from a trellis-level reference model.
module tb_acs_pm;

    localparam int PM_W    = 8;
    localparam int INIT_PM = 16;
    localparam int N_SYM   = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            bm_valid = 1'b0;
    logic [1:0]      hd [8];
    logic [3:0]      dec_bits;
    logic            dec_valid;
    logic [1:0]      best_state;
    logic [PM_W-1:0] best_pm;
    logic            frame_done;
    logic            busy;

    logic            rst4 = 1'b1;
    logic            start4 = 1'b0;
    logic            bm4 = 1'b0;
    logic [1:0]      h4 = 2'd0;
    logic [3:0]      dec_bits4;
    logic            dec_valid4;
    logic [1:0]      best_state4;
    logic [3:0]      best_pm4;
    logic            frame_done4;
    logic            busy4;

    acs_pm #(.PM_W(PM_W), .INIT_PM(INIT_PM), .N_SYM(N_SYM)) dut (
        .clk(clk), .rst(rst), .start(start), .bm_valid(bm_valid),
        .hamd_1(hd[0]), .hamd_2(hd[1]), .hamd_3(hd[2]), .hamd_4(hd[3]),
        .hamd_5(hd[4]), .hamd_6(hd[5]), .hamd_7(hd[6]), .hamd_8(hd[7]),
        .dec_bits(dec_bits), .dec_valid(dec_valid),
        .best_state(best_state), .best_pm(best_pm),
        .frame_done(frame_done), .busy(busy)
    );

    acs_pm #(.PM_W(4), .INIT_PM(4), .N_SYM(8)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .bm_valid(bm4),
        .hamd_1(h4), .hamd_2(h4), .hamd_3(h4), .hamd_4(h4),
        .hamd_5(h4), .hamd_6(h4), .hamd_7(h4), .hamd_8(h4),
        .dec_bits(dec_bits4), .dec_valid(dec_valid4),
        .best_state(best_state4), .best_pm(best_pm4),
        .frame_done(frame_done4), .busy(busy4)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state (0 idle, 1 running, 2 reporting).
    int m_pm [4];
    int m_cnt, m_st, m_dec, m_dv, m_fd, m_bs, m_bpm;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_init_pm();
        m_pm[0] = 0;
        for (int s = 1; s < 4; s++) m_pm[s] = INIT_PM;
    endfunction

    function automatic void model_reset();
        model_init_pm();
        m_cnt = 0; m_st = 0; m_dec = 0; m_dv = 0;
        m_fd = 0; m_bs = 0; m_bpm = 0;
    endfunction

    // One trellis step: new state n = 2u + (old >> 1), so the two
    // predecessors of n are 2*(n&1) and 2*(n&1)+1.
    function automatic void model_acs();
        int nw [4];
        int half, allhi, d;
        half = 1 << (PM_W - 1);
        d = 0;
        allhi = 1;
        for (int n = 0; n < 4; n++) begin
            int o0, c0, c1;
            o0 = 2 * (n % 2);
            c0 = m_pm[o0] + int'(hd[2*n]);
            c1 = m_pm[o0+1] + int'(hd[2*n+1]);
            if (c1 < c0) begin
                nw[n] = c1;
                d = d | (1 << n);
            end else begin
                nw[n] = c0;
            end
            if (((nw[n] / half) % 2) == 0) allhi = 0;
        end
        for (int n = 0; n < 4; n++)
            m_pm[n] = (nw[n] - (allhi != 0 ? half : 0)) % (2 * half);
        m_dec = d;
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_reset();
        end else begin
            m_dv = 0;
            m_fd = 0;
            if (start) begin
                m_st = 1;
                m_cnt = 0;
                model_init_pm();
            end else if (m_st == 1 && bm_valid) begin
                model_acs();
                m_dv = 1;
                m_cnt++;
                if (m_cnt == N_SYM) m_st = 2;
            end else if (m_st == 2) begin
                m_bs = 0;
                for (int s = 1; s < 4; s++)
                    if (m_pm[s] < m_pm[m_bs]) m_bs = s;
                m_bpm = m_pm[m_bs];
                m_fd = 1;
                m_st = 0;
            end
        end
    endfunction

    function automatic logic [31:0] dut_pm();
        return {dut.pm[3], dut.pm[2], dut.pm[1], dut.pm[0]};
    endfunction

    function automatic logic [31:0] mdl_pm();
        return {8'(m_pm[3]), 8'(m_pm[2]), 8'(m_pm[1]), 8'(m_pm[0])};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("dec_valid", 32'(dec_valid), 32'(m_dv));
        check("dec_bits", 32'(dec_bits), 32'(m_dec));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("busy", 32'(busy), 32'(m_st != 0));
        check("best_state", 32'(best_state), 32'(m_bs));
        check("best_pm", 32'(best_pm), 32'(m_bpm));
        check("pm", dut_pm(), mdl_pm());
        check("cnt", 32'(dut.cnt), 32'(m_cnt));
    endtask

    task automatic set_hd(input int a0, input int a1, input int a2,
                          input int a3, input int a4, input int a5,
                          input int a6, input int a7);
        hd[0] = 2'(a0); hd[1] = 2'(a1); hd[2] = 2'(a2); hd[3] = 2'(a3);
        hd[4] = 2'(a4); hd[5] = 2'(a5); hd[6] = 2'(a6); hd[7] = 2'(a7);
    endtask

    task automatic rand_hd();
        for (int i = 0; i < 8; i++) hd[i] = 2'($urandom_range(0, 2));
    endtask

    // Branch metrics from the (7,5) encoder for the received symbol.
    task automatic hd_from_rx(input logic r0, input logic r1);
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 2; j++) begin
                int o, u, e0, e1;
                o = 2 * (n % 2) + j;
                u = n / 2;
                e0 = u ^ (o / 2) ^ (o % 2);
                e1 = u ^ (o % 2);
                hd[2*n+j] = 2'(int'(e0 != int'(r0)) + int'(e1 != int'(r1)));
            end
        end
    endtask

    task automatic run_frame(input logic [15:0] data, input int exp_pm);
        start = 1'b1; bm_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < N_SYM; k++) begin
            hd_from_rx(data[15-2*k], data[14-2*k]);
            bm_valid = 1'b1;
            tick();
        end
        bm_valid = 1'b0;
        tick();
        check("frame_fd", 32'(frame_done), 32'd1);
        check("frame_bs", 32'(best_state), 32'd0);
        check("frame_bpm", 32'(best_pm), 32'(exp_pm));
        tick();
    endtask

    logic [15:0] exp4 [4];
    logic [31:0] saved;
    logic        seen_fd;

    initial begin
        exp4[0] = 16'h6262; exp4[1] = 16'h4444;
        exp4[2] = 16'h6666; exp4[3] = 16'h0000;
        set_hd(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // Narrow-metric instance: normalisation after the fourth step.
        @(posedge clk); #1;
        rst4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; bm4 = 1'b1; h4 = 2'd2;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("norm_pm", 32'({dut4.pm[3], dut4.pm[2], dut4.pm[1],
                                  dut4.pm[0]}), 32'(exp4[i]));
        end
        bm4 = 1'b0; rst4 = 1'b1;

        // Reset state.
        tick();
        check("rst_pm", dut_pm(), 32'h1010_1000);
        rst = 1'b0;
        tick();

        // Single symbol, received 11.
        start = 1'b1;
        tick();
        start = 1'b0;
        set_hd(2, 0, 1, 1, 0, 2, 1, 1);
        bm_valid = 1'b1;
        tick();
        bm_valid = 1'b0;
        check("t1_pm", dut_pm(), 32'h1100_1102);
        check("t1_dec", 32'(dec_bits), 32'd0);
        check("t1_dv", 32'(dec_valid), 32'd1);

        // Error-free and single-error frames.
        run_frame(16'hE170, 0);
        run_frame(16'h6170, 1);

        // Tie-break then a three-cycle gap.
        start = 1'b1;
        tick();
        start = 1'b0;
        set_hd(1, 1, 1, 1, 1, 1, 1, 1);
        bm_valid = 1'b1;
        tick();
        check("tie_dec", 32'(dec_bits & 4'b1010), 32'd0);
        bm_valid = 1'b0;
        saved = dut_pm();
        for (int i = 0; i < 3; i++) begin
            rand_hd();
            tick();
            check("gap_dv", 32'(dec_valid), 32'd0);
        end
        check("gap_pm", dut_pm(), mdl_pm());
        check("gap_hold", 32'(mdl_pm() == saved), 32'd1);

        // Abort with start at symbol 5 together with bm_valid.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_hd(); bm_valid = 1'b1;
            tick();
        end
        rand_hd(); start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_pm", dut_pm(), 32'h1010_1000);
        check("abort_cnt", 32'(dut.cnt), 32'd0);
        seen_fd = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_hd(); bm_valid = (k < 3);
            tick();
            seen_fd = seen_fd | frame_done;
        end
        check("abort_nofd", 32'(seen_fd), 32'd0);

        // Reset at symbol 3.
        for (int k = 0; k < 3; k++) begin
            rand_hd(); bm_valid = 1'b1;
            tick();
        end
        rst = 1'b1; bm_valid = 1'b1;
        tick();
        check("mrst_dv", 32'(dec_valid), 32'd0);
        check("mrst_dec", 32'(dec_bits), 32'd0);
        check("mrst_bs", 32'(best_state), 32'd0);
        check("mrst_bpm", 32'(best_pm), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_idle", 32'(dut.state), 32'd0);
        rst = 1'b0; bm_valid = 1'b0;
        tick();

        // Randomised frames with gaps and occasional aborts.
        for (int f = 0; f < 6; f++) begin
            start = 1'b1; bm_valid = 1'b0;
            tick();
            start = 1'b0;
            for (int c = 0; c < 20; c++) begin
                rand_hd();
                bm_valid = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 40) == 0);
                tick();
            end
            start = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
